// File: rtl/gpio_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_bank_pkg
//  Brief    : Shared register-select encoding for the GPIO port bank.
//  Revision : 1.0 - initial release
// ============================================================================
package gpio_bank_pkg;

    localparam logic [1:0] REG_PORT  = 2'd0;
    localparam logic [1:0] REG_TRIS  = 2'd1;
    localparam logic [1:0] REG_IOCEN = 2'd2;
    localparam logic [1:0] REG_IOCF  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gpio_port_slice.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_port_slice
//  Brief    : One GPIO port: latch/TRIS/IOCEN/IOCF, pin synchroniser,
//             change detect and interrupt-on-change strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_port_slice #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_port,
    input  logic             i_wr_tris,
    input  logic             i_wr_iocen,
    input  logic             i_wr_iocf,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_port_rd,
    output logic [WIDTH-1:0] o_tris,
    output logic [WIDTH-1:0] o_iocen,
    output logic [WIDTH-1:0] o_iocf,
    output logic [WIDTH-1:0] o_pin_out,
    output logic [WIDTH-1:0] o_pin_oe,
    output logic             o_irq_strobe
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_latch;
    logic [WIDTH-1:0] r_tris;
    logic [WIDTH-1:0] r_iocen;
    logic [WIDTH-1:0] r_iocf;
    logic [WIDTH-1:0] r_iocf_d;
    logic             r_strobe;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_iocf_next;

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_set       = (w_sync ^ r_prev) & r_iocen & r_tris;
    assign w_clr       = i_wr_iocf ? i_wr_data : '0;
    // OR-ing the set term last lets a new change win over a coincident W1C
    assign w_iocf_next = (r_iocf & ~w_clr) | w_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev   <= '0;
            r_latch  <= '0;
            r_tris   <= '1;
            r_iocen  <= '0;
            r_iocf   <= '0;
            r_iocf_d <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_sync[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
            if (i_wr_port) begin
                r_latch <= i_wr_data;
            end
            if (i_wr_tris) begin
                r_tris <= i_wr_data;
            end
            if (i_wr_iocen) begin
                r_iocen <= i_wr_data;
            end
            r_iocf   <= w_iocf_next;
            r_iocf_d <= r_iocf;
            // Fires the cycle after any flag bit rose from 0 to 1
            r_strobe <= |(r_iocf & ~r_iocf_d);
        end
    end

    assign o_port_rd    = (r_tris & w_sync) | (~r_tris & r_latch);
    assign o_tris       = r_tris;
    assign o_iocen      = r_iocen;
    assign o_iocf       = r_iocf;
    assign o_pin_out    = r_latch;
    assign o_pin_oe     = ~r_tris;
    assign o_irq_strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/gpio_port_bank.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_port_bank
//  Brief    : Bank of GPIO ports with register address decode and read mux.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_port_bank #(
    parameter int NUM_PORTS   = 2,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 reg_addr,
    input  logic                       wr_en,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    input  logic [NUM_PORTS*WIDTH-1:0] physical_in,
    output logic [NUM_PORTS*WIDTH-1:0] physical_out,
    output logic [NUM_PORTS*WIDTH-1:0] physical_oe,
    output logic [NUM_PORTS-1:0]       irq_strobe
);

    import gpio_bank_pkg::*;

    logic [1:0]       w_idx;
    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_rd;
    logic             w_unused_data;

    logic [WIDTH-1:0] w_port_rd [NUM_PORTS];
    logic [WIDTH-1:0] w_tris    [NUM_PORTS];
    logic [WIDTH-1:0] w_iocen   [NUM_PORTS];
    logic [WIDTH-1:0] w_iocf    [NUM_PORTS];

    assign w_idx         = reg_addr[3:2];
    assign w_sel         = reg_addr[1:0];
    assign w_unused_data = ^data_in;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            localparam logic [1:0] c_idx = 2'(p);
            logic w_hit;

            assign w_hit = wr_en && (w_idx == c_idx);

            gpio_port_slice #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_slice (
                .clk          (clk),
                .rst          (rst),
                .i_wr_port    (w_hit && (w_sel == REG_PORT)),
                .i_wr_tris    (w_hit && (w_sel == REG_TRIS)),
                .i_wr_iocen   (w_hit && (w_sel == REG_IOCEN)),
                .i_wr_iocf    (w_hit && (w_sel == REG_IOCF)),
                .i_wr_data    (data_in[WIDTH-1:0]),
                .i_pin        (physical_in[p*WIDTH +: WIDTH]),
                .o_port_rd    (w_port_rd[p]),
                .o_tris       (w_tris[p]),
                .o_iocen      (w_iocen[p]),
                .o_iocf       (w_iocf[p]),
                .o_pin_out    (physical_out[p*WIDTH +: WIDTH]),
                .o_pin_oe     (physical_oe[p*WIDTH +: WIDTH]),
                .o_irq_strobe (irq_strobe[p])
            );
        end
    endgenerate

    // Unpopulated port indices fall through with the zero default
    always_comb begin
        w_rd = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_idx == 2'(p)) begin
                case (w_sel)
                    REG_PORT:  w_rd = w_port_rd[p];
                    REG_TRIS:  w_rd = w_tris[p];
                    REG_IOCEN: w_rd = w_iocen[p];
                    default:   w_rd = w_iocf[p];
                endcase
            end
        end
    end

    assign data_out = 8'(w_rd);

endmodule
`default_nettype wire

// File: tb/tb_gpio_port_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_port_bank
//  Brief    : Directed and randomised bench for gpio_port_bank against a
//             cycle-indexed pin-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_port_bank;

    localparam int NP = 2;
    localparam int W  = 8;
    localparam int SS = 2;
    localparam logic [7:0] c_WMASK = 8'((1 << W) - 1);

    logic              clk;
    logic              rst;
    logic [3:0]        reg_addr;
    logic              wr_en;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [NP*W-1:0]   physical_in;
    logic [NP*W-1:0]   physical_out;
    logic [NP*W-1:0]   physical_oe;
    logic [NP-1:0]     irq_strobe;

    gpio_port_bank #(
        .NUM_PORTS   (NP),
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_addr     (reg_addr),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .physical_in  (physical_in),
        .physical_out (physical_out),
        .physical_oe  (physical_oe),
        .irq_strobe   (irq_strobe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: registers plus the pin level captured at every edge
    logic [7:0]      m_latch [NP];
    logic [7:0]      m_tris  [NP];
    logic [7:0]      m_iocen [NP];
    logic [7:0]      m_iocf  [NP];
    bit              m_rose  [NP];
    bit              m_strobe[NP];
    logic [NP*W-1:0] hist [0:4095];
    int              ecnt     = 0;
    int              last_rst = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // The synchronised view after edge e is the pin level seen SS-1 edges before
    function automatic logic [NP*W-1:0] sync_at(input int e);
        int k;
        k = e - SS + 1;
        if (k <= last_rst || k < 0) return '0;
        return hist[k];
    endfunction

    function automatic logic [7:0] pin_of(input logic [NP*W-1:0] v, input int p);
        return 8'(v[p*W +: W]);
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] a);
        int p;
        logic [7:0] s;
        p = int'(a[3:2]);
        if (p >= NP) return 8'h00;
        s = pin_of(sync_at(ecnt), p);
        case (a[1:0])
            2'd0:    return ((m_tris[p] & s) | (~m_tris[p] & m_latch[p])) & c_WMASK;
            2'd1:    return m_tris[p];
            2'd2:    return m_iocen[p];
            default: return m_iocf[p];
        endcase
    endfunction

    task automatic step(input bit r, input bit we, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] setv;
        logic [7:0] clr;
        logic [7:0] nf;
        int wp;
        rst      = r;
        wr_en    = we;
        reg_addr = a;
        data_in  = d;
        @(posedge clk);
        ecnt++;
        hist[ecnt] = physical_in;
        if (r) begin
            for (int p = 0; p < NP; p++) begin
                m_latch[p]  = 8'h00;
                m_tris[p]   = c_WMASK;
                m_iocen[p]  = 8'h00;
                m_iocf[p]   = 8'h00;
                m_rose[p]   = 1'b0;
                m_strobe[p] = 1'b0;
            end
            last_rst = ecnt;
        end else begin
            wp = int'(a[3:2]);
            for (int p = 0; p < NP; p++) begin
                setv = (pin_of(sync_at(ecnt-1), p) ^ pin_of(sync_at(ecnt-2), p))
                       & m_iocen[p] & m_tris[p];
                clr  = (we && wp == p && a[1:0] == 2'd3) ? (d & c_WMASK) : 8'h00;
                nf   = (m_iocf[p] & ~clr) | setv;
                m_strobe[p] = m_rose[p];
                m_rose[p]   = (nf & ~m_iocf[p]) != 8'h00;
                m_iocf[p]   = nf;
                if (we && wp == p) begin
                    case (a[1:0])
                        2'd0:    m_latch[p] = d & c_WMASK;
                        2'd1:    m_tris[p]  = d & c_WMASK;
                        2'd2:    m_iocen[p] = d & c_WMASK;
                        default: ;
                    endcase
                end
            end
        end
        #1;
        wr_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic wr(input int p, input int s, input logic [7:0] d);
        step(1'b0, 1'b1, {2'(p), 2'(s)}, d);
    endtask

    task automatic rd(input int p, input int s, output logic [7:0] v);
        reg_addr = {2'(p), 2'(s)};
        #1;
        v = data_out;
    endtask

    task automatic full_check();
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("phys_out_p%0d", p), 8'(physical_out[p*W +: W]), m_latch[p]);
            chk($sformatf("phys_oe_p%0d", p), 8'(physical_oe[p*W +: W]), ~m_tris[p] & c_WMASK);
            chk($sformatf("irq_p%0d", p), 8'(irq_strobe[p]), 8'(m_strobe[p]));
        end
        for (int a = 0; a < 16; a++) begin
            reg_addr = 4'(a);
            #1;
            chk($sformatf("rd_a%0d", a), data_out, model_read(4'(a)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        rst         = 1'b0;
        wr_en       = 1'b0;
        reg_addr    = 4'h0;
        data_in     = 8'h00;
        physical_in = '0;
        hist[0]     = '0;

        // Reset state
        step(1'b1, 1'b0, 4'h0, 8'h00);
        step(1'b1, 1'b0, 4'h0, 8'h00);
        full_check();
        rd(0, 1, v);  chk("rst_tris", v, 8'hFF);
        rd(1, 3, v);  chk("rst_iocf", v, 8'h00);
        chk("rst_oe",  8'(physical_oe), 8'h00);
        chk("rst_out", 8'(physical_out), 8'h00);
        chk("rst_irq", 8'(irq_strobe), 8'h00);

        // Mixed read: low nibble from pins, high nibble from latch
        wr(0, 1, 8'h0F);
        wr(0, 0, 8'hA5);
        physical_in[7:0] = 8'h3C;
        idle();
        idle();
        full_check();
        rd(0, 0, v);  chk("mixed_port", v, 8'hAC);
        chk("mixed_oe", 8'(physical_oe[7:0]), 8'hF0);

        // Interrupt-on-change on port 1 bit 0
        wr(1, 2, 8'h01);
        physical_in[8] = 1'b1;
        idle(); rd(1, 3, v); chk("ioc_e1_flag", v, 8'h00);
        idle(); rd(1, 3, v); chk("ioc_e2_flag", v, 8'h00);
        idle(); rd(1, 3, v); chk("ioc_e3_flag", v, 8'h01);
        chk("ioc_e3_irq", 8'(irq_strobe), 8'h00);
        idle(); chk("ioc_e4_irq", 8'(irq_strobe), 8'h02);
        idle(); chk("ioc_e5_irq", 8'(irq_strobe), 8'h00);
        physical_in[8] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("ioc_retoggle_irq", 8'(irq_strobe), 8'h00);
        end
        full_check();

        // W1C and set-over-clear priority
        wr(1, 2, 8'h03);
        physical_in[9] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            full_check();
        end
        rd(1, 3, v);  chk("w1c_pre", v, 8'h03);
        wr(1, 3, 8'h01);
        rd(1, 3, v);  chk("w1c_bit0", v, 8'h02);
        physical_in[9] = 1'b0;
        idle();
        idle();
        wr(1, 3, 8'h02);
        rd(1, 3, v);  chk("w1c_priority", v, 8'h02);
        idle();
        chk("w1c_no_pulse", 8'(irq_strobe), 8'h00);
        full_check();

        // Masking by IOCEN=0 (low nibble) and TRIS=0 (high nibble)
        wr(0, 2, 8'hF0);
        for (int t = 0; t < 2; t++) begin
            physical_in[7:0] = ~physical_in[7:0];
            for (int i = 0; i < 4; i++) begin
                idle();
                full_check();
            end
        end
        rd(0, 3, v);  chk("mask_iocf", v, 8'h00);

        // Writes to an unpopulated port index
        wr(3, 0, 8'hFF);
        wr(3, 1, 8'h00);
        wr(3, 2, 8'hFF);
        for (int s = 0; s < 4; s++) begin
            rd(3, s, v);
            chk($sformatf("idx3_sel%0d", s), v, 8'h00);
        end
        full_check();

        // Reset coinciding with a TRIS write and a due strobe
        wr(1, 3, 8'hFF);
        physical_in[8] = 1'b1;
        idle();
        idle();
        idle();
        rd(1, 3, v);  chk("midrst_pending", v, 8'h01);
        step(1'b1, 1'b1, {2'd1, 2'd1}, 8'h00);
        rd(1, 1, v);  chk("midrst_tris", v, 8'hFF);
        rd(1, 3, v);  chk("midrst_iocf", v, 8'h00);
        chk("midrst_irq", 8'(irq_strobe), 8'h00);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("midrst_irq_after", 8'(irq_strobe), 8'h00);
        end
        full_check();

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                physical_in = (NP*W)'($urandom);
            end
            step(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom), 8'($urandom));
            full_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_port_bank.md
GPIO_PORT_BANK -- requirements
Module: gpio_port_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of ports (1..4).
REQ-002 SHALL have parameter WIDTH, default 8, bits per port (1..8).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..3).
REQ-004 SHALL have port clk  input  1  the single clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous to clk, active-high.
REQ-006 SHALL have port reg_addr  input  4  {port index[3:2], register select[1:0]}.
REQ-007 SHALL have port wr_en  input  1  write strobe for reg_addr.
REQ-008 SHALL have port data_in  input  8  write data, bits [WIDTH-1:0] used.
REQ-009 SHALL have port data_out  output  8  read data, combinational from reg_addr.
REQ-010 SHALL have port physical_in  input  NUM_PORTS*WIDTH  pin levels, port p at [p*WIDTH +: WIDTH].
REQ-011 SHALL have port physical_out  output  NUM_PORTS*WIDTH  output latches.
REQ-012 SHALL have port physical_oe  output  NUM_PORTS*WIDTH  output enables, equal to ~TRIS.
REQ-013 SHALL have port irq_strobe  output  NUM_PORTS  one-cycle interrupt-on-change pulse per port.

Function
REQ-014 SHALL decode register select as 0=PORT, 1=TRIS, 2=IOCEN, 3=IOCF.
REQ-015 SHALL ignore writes to, and read 0 from, port indices >= NUM_PORTS; bits [7:WIDTH] of data_out SHALL read 0.
REQ-016 SHALL pass each physical_in bit through SYNC_STAGES flops; "sync" is the last stage.
REQ-017 SHALL return on PORT read, per bit, sync if TRIS=1, else the output latch.
REQ-018 SHALL on PORT write load the output latch for all bits, including input-configured bits, at the next edge.
REQ-019 SHALL on TRIS/IOCEN write load that register at the next edge; reads return the register.
REQ-020 SHALL keep a one-cycle-delayed copy "prev" of sync; a bit changes when sync!=prev.
REQ-021 SHALL set IOCF bit when it changes, its IOCEN=1 and its TRIS=1; flags are sticky.
REQ-022 SHALL clear IOCF bits written with 1 (W1C); writing 0 SHALL leave the bit unchanged.
REQ-023 SHALL give set priority over W1C clear on the same bit in the same cycle.
REQ-024 SHALL pulse irq_strobe[p] for exactly the cycle after an IOCF bit of port p goes 0->1; already-set bits SHALL not re-pulse.
REQ-025 SHALL give pin-to-flag latency of SYNC_STAGES+1 edges and pin-to-strobe latency of SYNC_STAGES+2 edges.
REQ-026 SHALL not set flags from a TRIS or IOCEN write alone; only a sync change counts.
REQ-027 SHALL have physical_out equal the latch and physical_oe equal ~TRIS continuously.

Reset
REQ-028 SHALL on rst set TRIS to all ones, latch, IOCEN, IOCF, irq_strobe to 0.
REQ-029 SHALL on rst load the synchroniser stages and prev with 0, so that no spurious flag occurs after reset (IOCEN=0).
REQ-030 SHALL give rst priority over a coincident wr_en, with the write lost.

Structure
REQ-031 SHALL place the register-select constants (REG_PORT, REG_TRIS, REG_IOCEN, REG_IOCF) in a shared package gpio_bank_pkg.
REQ-032 SHALL implement one port (registers, synchroniser, change detect, strobe) in the sub-module gpio_port_slice, instantiated NUM_PORTS times by generate.
REQ-033 SHALL have the top level hold only the address decode and the read mux.

Verification
REQ-034 SHALL cover reset: after rst, TRIS=0xFF, PORT latch=0x00, physical_oe=0, irq_strobe=0, data_out of IOCF=0x00.
REQ-035 SHALL cover mixed read: TRIS=0x0F, latch=0xA5, pins=0x3C -> PORT read=0xAC after SYNC_STAGES edges.
REQ-036 SHALL cover IOC: port1 IOCEN=0x01, TRIS=0xFF, pin1[0] 0->1 -> IOCF=0x01 at edge 3, irq_strobe=2'b10 one cycle at edge 4; a further toggle gives no pulse.
REQ-037 SHALL cover W1C/priority: IOCF=0x03, write 0x01 -> 0x02; W1C of bit1 coincident with a new change on bit1 -> bit1 stays 1.
REQ-038 SHALL cover masking: pin toggles with IOCEN=0 or TRIS=0 -> IOCF stays 0x00; a write to port index 3 with NUM_PORTS=2 has no effect and reads 0.
REQ-039 SHALL cover reset mid-operation: rst asserted with wr_en to TRIS=0x00 and pending flags -> TRIS=0xFF, IOCF=0, no strobe.
